// File: rtl/scnn_ip_streamer.sv
// Streams one captured compressed activation vector to the PE array, LANES entries per beat,
// turning zero-run lengths into absolute positions. Optional format checking: SCNN_IP_STREAM_CHK_EN.
module scnn_ip_streamer #(
    parameter int VEC_LEN = 16,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 5,
    parameter int LANES   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(VEC_LEN+1)-1:0] in_count,
    input  logic [VEC_LEN*DATA_W-1:0]    in_vals,
    input  logic [VEC_LEN*IDX_W-1:0]     in_zrun,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*DATA_W-1:0]      out_vals,
    output logic [LANES*IDX_W-1:0]       out_pos,
    output logic [LANES-1:0]             out_mask,
    output logic                         out_last,
    output logic                         err
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam int ENT_W = $clog2(VEC_LEN);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]        state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  base_reg;
    logic [DATA_W-1:0] vals_reg [VEC_LEN];
    logic [IDX_W-1:0]  zrun_reg [VEC_LEN];

    logic              streaming;
    logic              last;
    logic              fire;
    logic              capture;
    logic [CNT_W-1:0]  count_clamped;
    logic [ENT_W-1:0]  lane_ent [LANES];
    logic [LANES-1:0]  lane_valid;
    logic [IDX_W-1:0]  pos_raw [LANES];
    logic [IDX_W-1:0]  base_next;

    assign streaming     = (state_reg == ST_STREAM);
    assign last          = ({1'b0, ptr_reg} + (CNT_W+1)'(LANES)) >= {1'b0, count_reg};
    assign fire          = streaming & out_ready;
    assign in_ready      = ~streaming | (out_ready & last);
    assign capture       = in_valid & in_ready;
    assign count_clamped = (in_count > CNT_W'(VEC_LEN)) ? CNT_W'(VEC_LEN) : in_count;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : lane_g
            assign lane_ent[gi]   = ENT_W'(ptr_reg + CNT_W'(gi));
            assign lane_valid[gi] = streaming &&
                                    (({1'b0, ptr_reg} + (CNT_W+1)'(gi)) < {1'b0, count_reg});
            assign out_vals[gi*DATA_W +: DATA_W] = lane_valid[gi] ? vals_reg[lane_ent[gi]] : '0;
            assign out_pos[gi*IDX_W +: IDX_W]    = lane_valid[gi] ? pos_raw[gi] : '0;
        end
    endgenerate

    // Prefix sum across lanes; base_next is pos(last lane)+1, only used on non-final beats
    // where every lane is valid.
    always_comb begin
        base_next = base_reg;
        for (int k = 0; k < LANES; k++) begin
            pos_raw[k] = base_next + zrun_reg[lane_ent[k]];
            base_next  = pos_raw[k] + IDX_W'(1);
        end
    end

    assign out_valid = streaming;
    assign out_last  = streaming & last;
    assign out_mask  = lane_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            ptr_reg   <= '0;
            base_reg  <= '0;
        end else if (capture) begin
            state_reg <= ST_STREAM;
            count_reg <= count_clamped;
            ptr_reg   <= '0;
            base_reg  <= '0;
        end else if (fire) begin
            if (last) begin
                state_reg <= ST_IDLE;
            end else begin
                ptr_reg  <= ptr_reg + CNT_W'(LANES);
                base_reg <= base_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                vals_reg[i] <= in_vals[i*DATA_W +: DATA_W];
                zrun_reg[i] <= in_zrun[i*IDX_W +: IDX_W];
            end
        end
    end

`ifdef SCNN_IP_STREAM_CHK_EN
    logic [IDX_W:0] pos_wide [LANES];
    logic           pos_over;
    logic           err_reg;

    // A lane can only overflow the wide adder if an earlier valid lane already exceeded the range.
    always_comb begin
        logic [IDX_W:0] wprev;
        wprev    = {1'b0, base_reg};
        pos_over = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            pos_wide[k] = wprev + {1'b0, zrun_reg[lane_ent[k]]};
            wprev       = pos_wide[k] + (IDX_W+1)'(1);
            if (lane_valid[k] && (pos_wide[k] > (IDX_W+1)'(VEC_LEN - 1)))
                pos_over = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if ((capture && (in_count > CNT_W'(VEC_LEN))) || (fire && pos_over))
            err_reg <= 1'b1;
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_scnn_ip_streamer.sv
// Directed bench for scnn_ip_streamer: a beat table plus hand sequences for backpressure,
// back-to-back capture, mid-stream reset and (with SCNN_IP_STREAM_CHK_EN) the error flag.
module tb_scnn_ip_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_count;
    logic [255:0] in_vals;
    logic [79:0]  in_zrun;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_vals;
    logic [19:0]  out_pos;
    logic [3:0]   out_mask;
    logic         out_last;
    logic         err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scnn_ip_streamer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .in_vals(in_vals), .in_zrun(in_zrun),
        .out_valid(out_valid), .out_ready(out_ready), .out_vals(out_vals),
        .out_pos(out_pos), .out_mask(out_mask), .out_last(out_last), .err(err)
    );

    typedef struct {
        logic [4:0]   cnt;
        logic [255:0] vals;
        logic [79:0]  zrun;
        int           beat;
        logic [63:0]  ev;
        logic [19:0]  ep;
        logic [3:0]   em;
        logic         el;
    } row_t;

    row_t rows [13];

    function automatic logic [255:0] seq_vals(input int start, input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*16 +: 16] = 16'(start + i);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] ev, input logic [19:0] ep,
                            input logic [3:0] em, input logic el);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".vals"},  out_vals, ev);
        chk({tag, ".pos"},   64'(out_pos), 64'(ep));
        chk({tag, ".mask"},  64'(out_mask), 64'(em));
        chk({tag, ".last"},  64'(out_last), 64'(el));
    endtask

    task automatic load(input logic [4:0] c, input logic [255:0] v, input logic [79:0] z);
        in_count = c;
        in_vals  = v;
        in_zrun  = z;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [63:0] ev_b;
    logic [19:0] ep_b;

    initial begin
        // Beat table
        rows[0] = '{cnt:5'd5, vals:seq_vals(10, 5), zrun:80'({5'd0, 5'd1, 5'd3, 5'd0, 5'd2}),
                    beat:0, ev:{16'd13, 16'd12, 16'd11, 16'd10},
                    ep:{5'd9, 5'd7, 5'd3, 5'd2}, em:4'b1111, el:1'b0};
        rows[1] = '{cnt:5'd5, vals:'0, zrun:'0, beat:1, ev:{48'd0, 16'd14},
                    ep:{15'd0, 5'd10}, em:4'b0001, el:1'b1};
        rows[2] = '{cnt:5'd0, vals:seq_vals(50, 16), zrun:80'({5'd3, 5'd3}), beat:0,
                    ev:64'd0, ep:20'd0, em:4'b0000, el:1'b1};
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 4; l++) begin
                ev_b[l*16 +: 16] = 16'(1 + 4*b + l);
                ep_b[l*5 +: 5]   = 5'(4*b + l);
            end
            rows[3+b] = '{cnt:5'd16, vals:seq_vals(1, 16), zrun:'0, beat:b,
                          ev:ev_b, ep:ep_b, em:4'b1111, el:(b == 3)};
            for (int l = 0; l < 4; l++) ev_b[l*16 +: 16] = 16'(200 + 4*b + l);
            rows[8+b] = '{cnt:5'd20, vals:seq_vals(200, 16), zrun:'0, beat:b,
                          ev:ev_b, ep:ep_b, em:4'b1111, el:(b == 3)};
        end
        rows[7]  = '{cnt:5'd3, vals:seq_vals(100, 3), zrun:80'({5'd1, 5'd1, 5'd1}), beat:0,
                     ev:{16'd0, 16'd102, 16'd101, 16'd100},
                     ep:{5'd0, 5'd5, 5'd3, 5'd1}, em:4'b0111, el:1'b1};
        rows[12] = '{cnt:5'd2, vals:seq_vals(7, 2), zrun:80'({5'd15, 5'd20}), beat:0,
                     ev:{32'd0, 16'd8, 16'd7}, ep:{10'd0, 5'd4, 5'd20}, em:4'b0011, el:1'b1};

        rst = 1'b1; in_valid = 1'b0; in_count = '0; in_vals = '0; in_zrun = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.last",  64'(out_last), 64'd0);
        chk("rst.mask",  64'(out_mask), 64'd0);
        chk("rst.vals",  out_vals, 64'd0);
        chk("rst.pos",   64'(out_pos), 64'd0);
        chk("rst.err",   64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            if (rows[i].beat == 0) load(rows[i].cnt, rows[i].vals, rows[i].zrun);
            else @(negedge clk);
            $display("row %0d beat %0d: vals=%h pos=%h mask=%b last=%b", i, rows[i].beat,
                     out_vals, out_pos, out_mask, out_last);
            chk_beat($sformatf("row%0d", i), rows[i].ev, rows[i].ep, rows[i].em, rows[i].el);
            chk($sformatf("row%0d.in_ready", i), 64'(in_ready), 64'(rows[i].el));
            if (rows[i].el) begin
                @(negedge clk);
                chk($sformatf("row%0d.idle_after", i), 64'(out_valid), 64'd0);
                chk($sformatf("row%0d.ready_after", i), 64'(in_ready), 64'd1);
            end
        end
`ifndef SCNN_IP_STREAM_CHK_EN
        chk("err.tied_low", 64'(err), 64'd0);
`endif

        // Backpressure on beat 0 while a second vector waits on the input
        out_ready = 1'b0;
        load(5'd5, seq_vals(10, 5), 80'({5'd0, 5'd1, 5'd3, 5'd0, 5'd2}));
        in_count = 5'd1; in_vals = 256'(16'hBEEF); in_zrun = 80'(5'd4); in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            $display("stall cycle %0d: pos=%h mask=%b in_ready=%b", c, out_pos, out_mask, in_ready);
            chk_beat($sformatf("stall%0d", c), {16'd13, 16'd12, 16'd11, 16'd10},
                     {5'd9, 5'd7, 5'd3, 5'd2}, 4'b1111, 1'b0);
            chk($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'd0);
            if (c == 3) out_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        $display("beat1 after stall: pos=%h mask=%b last=%b", out_pos, out_mask, out_last);
        chk_beat("stall.beat1", {48'd0, 16'd14}, {15'd0, 5'd10}, 4'b0001, 1'b1);
        chk("b2b.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("back-to-back beat0: vals=%h pos=%h mask=%b", out_vals, out_pos, out_mask);
        chk_beat("b2b.beat0", {48'd0, 16'hBEEF}, {15'd0, 5'd4}, 4'b0001, 1'b1);
        @(negedge clk);
        chk("b2b.idle", 64'(out_valid), 64'd0);

        // Reset in the middle of a 16-entry vector
        load(5'd16, seq_vals(1, 16), '0);
        chk_beat("mid.beat0", {16'd4, 16'd3, 16'd2, 16'd1}, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1111, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-stream reset: out_valid=%b in_ready=%b", out_valid, in_ready);
        chk("mid.valid", 64'(out_valid), 64'd0);
        chk("mid.in_ready", 64'(in_ready), 64'd1);
        chk("mid.mask", 64'(out_mask), 64'd0);
        @(negedge clk);
        chk("mid.discarded", 64'(out_valid), 64'd0);

`ifdef SCNN_IP_STREAM_CHK_EN
        load(5'd2, seq_vals(1, 2), 80'({5'd0, 5'd15}));
        chk("chk.err_before", 64'(err), 64'd0);
        chk_beat("chk.beat0", {32'd0, 16'd2, 16'd1}, {10'd0, 5'd16, 5'd15}, 4'b0011, 1'b1);
        @(negedge clk);
        $display("position overflow: err=%b", err);
        chk("chk.err_set", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        chk("chk.err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("chk.err_cleared", 64'(err), 64'd0);
        load(5'd17, seq_vals(1, 16), '0);
        $display("oversized count: err=%b", err);
        chk("chk.err_count", 64'(err), 64'd1);
        repeat (4) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
